// File: rtl/sd_credit_tx.sv
// Credit-gated transmit end of a long-wire link.
// Upstream words land in a 2-entry holding buffer and are launched as
// registered valid/data only while the link holds credits. Every output
// comes straight from a flop so the long route starts timing-clean.
module sd_credit_tx #(
  parameter int width   = 8,
  parameter int credits = 4,
  parameter int cnt_w   = $clog2(credits + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  output logic             p_vld,
  output logic [width-1:0] p_data,
  input  logic             p_credit,
  output logic [cnt_w-1:0] cr_avail,
  output logic             cr_err
);

  localparam logic [cnt_w-1:0] cr_max = cnt_w'(credits);

  logic [width-1:0] buf_reg [2];
  logic             head_reg;
  logic             tail_reg;
  logic [1:0]       occ_reg;
  logic [1:0]       occ_next;
  logic [cnt_w-1:0] cr_reg;
  logic [cnt_w-1:0] cr_next;
  logic             err_reg;
  logic             err_next;
  logic             drdy_reg;
  logic             vld_reg;
  logic [width-1:0] data_reg;

  logic push;
  logic send;
  logic overflow;

  // Transfer decisions use registered state only, so a freshly pushed
  // word or a freshly returned credit takes effect one edge later.
  always_comb begin
    push     = c_srdy && drdy_reg;
    send     = (occ_reg != 2'd0) && (cr_reg != '0);
    overflow = p_credit && (cr_reg == cr_max) && !send;
  end

  // Post-edge buffer occupancy; a coincident push and pop leave it unchanged.
  always_comb begin
    occ_next = occ_reg;
    case ({push, send})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
  end

  // Credit count: minus one per send, plus one per returned credit,
  // saturating at the maximum with a sticky error on a surplus credit.
  always_comb begin
    cr_next  = cr_reg;
    err_next = err_reg;
    if (overflow) begin
      err_next = 1'b1;
    end else if (send && !p_credit) begin
      cr_next = cr_reg - cnt_w'(1);
    end else if (!send && p_credit) begin
      cr_next = cr_reg + cnt_w'(1);
    end
  end

  // Holding buffer storage; contents need no reset because the pointers do.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_reg[tail_reg] <= c_data;
    end
  end

  // Pointers, counters and registered link outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_reg <= 1'b0;
      tail_reg <= 1'b0;
      occ_reg  <= 2'd0;
      cr_reg   <= cr_max;
      err_reg  <= 1'b0;
      drdy_reg <= 1'b0;
      vld_reg  <= 1'b0;
      data_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= ~tail_reg;
      end
      if (send) begin
        head_reg <= ~head_reg;
        data_reg <= buf_reg[head_reg];
      end
      occ_reg  <= occ_next;
      cr_reg   <= cr_next;
      err_reg  <= err_next;
      drdy_reg <= (occ_next != 2'd2);
      vld_reg  <= send;
    end
  end

  assign c_drdy   = drdy_reg;
  assign p_vld    = vld_reg;
  assign p_data   = data_reg;
  assign cr_avail = cr_reg;
  assign cr_err   = err_reg;

endmodule
